// File: rtl/button_debouncer_multi.sv
// Multi-channel push-button debouncer: synchroniser, window filter, edge and long-press pulses.
// Output changes SYNC_STAGES + 2^CNT_W - 1 clocks after a stable input change; all outputs are registered.
module button_debouncer_multi #(
    parameter int                N_CH        = 4,
    parameter int                CNT_W       = 20,
    parameter int                SYNC_STAGES = 2,
    parameter int                LONG_W      = 26,
    parameter logic [N_CH-1:0]   RESET_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  pb_in,
    output logic [N_CH-1:0]  pb_out,
    output logic [N_CH-1:0]  pb_rise,
    output logic [N_CH-1:0]  pb_fall,
    output logic [N_CH-1:0]  pb_long,
    output logic             any_change
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [LONG_W-1:0] LONG_MAX = '1;

    logic [SYNC_STAGES-1:0][N_CH-1:0] sync;
    logic [N_CH-1:0]                  s;

    logic [N_CH-1:0][CNT_W-1:0]       cnt;
    logic [N_CH-1:0][CNT_W-1:0]       cnt_nxt;
    logic [N_CH-1:0][LONG_W-1:0]      lcnt;
    logic [N_CH-1:0][LONG_W-1:0]      lcnt_nxt;

    logic [N_CH-1:0]                  out_nxt;
    logic [N_CH-1:0]                  rise_nxt;
    logic [N_CH-1:0]                  fall_nxt;
    logic [N_CH-1:0]                  long_nxt;

    // The last synchroniser stage is the only view of the pins the filter ever sees.
    assign s = sync[SYNC_STAGES-1];

    always_comb begin
        cnt_nxt  = '0;
        lcnt_nxt = '0;
        out_nxt  = pb_out;
        long_nxt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (s[i] != pb_out[i]) begin
                cnt_nxt[i] = cnt[i] + CNT_W'(1);
                if (cnt[i] == CNT_MAX) begin
                    out_nxt[i] = s[i];
                end
            end

            // Long-press count saturates so the pulse fires once per press.
            if (pb_out[i]) begin
                if (lcnt[i] != LONG_MAX) begin
                    lcnt_nxt[i] = lcnt[i] + LONG_W'(1);
                end else begin
                    lcnt_nxt[i] = lcnt[i];
                end
                long_nxt[i] = (lcnt_nxt[i] == LONG_MAX) && (lcnt[i] != LONG_MAX);
            end
        end
        rise_nxt = out_nxt & ~pb_out;
        fall_nxt = ~out_nxt & pb_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync       <= {SYNC_STAGES{RESET_VAL}};
            cnt        <= '0;
            lcnt       <= '0;
            pb_out     <= RESET_VAL;
            pb_rise    <= '0;
            pb_fall    <= '0;
            pb_long    <= '0;
            any_change <= 1'b0;
        end else begin
            sync       <= {sync[SYNC_STAGES-2:0], pb_in};
            cnt        <= cnt_nxt;
            lcnt       <= lcnt_nxt;
            pb_out     <= out_nxt;
            pb_rise    <= rise_nxt;
            pb_fall    <= fall_nxt;
            pb_long    <= long_nxt;
            any_change <= |(rise_nxt | fall_nxt);
        end
    end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: directed scenarios plus random pin activity against a history-window model.
module tb_button_debouncer_multi;

    localparam int N_CH   = 4;
    localparam int CNT_W  = 4;
    localparam int SYNC   = 2;
    localparam int LONG_W = 6;
    localparam int WIN    = 1 << CNT_W;
    localparam int LONG_T = (1 << LONG_W) - 1;
    localparam int MAXE   = 8192;
    localparam logic [N_CH-1:0] RV = '0;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N_CH-1:0] pb_in = '0;
    logic [N_CH-1:0] pb_out, pb_rise, pb_fall, pb_long;
    logic            any_change;

    int n_tests = 0;
    int n_fail  = 0;

    button_debouncer_multi #(
        .N_CH(N_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LONG_W(LONG_W), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst(rst), .pb_in(pb_in), .pb_out(pb_out), .pb_rise(pb_rise),
        .pb_fall(pb_fall), .pb_long(pb_long), .any_change(any_change)
    );

    always #5 clk = ~clk;

    // Model: history of pins and reset per edge; a channel flips when the synchronised
    // pin has disagreed with the output for a full, reset-free window of edges.
    logic [N_CH-1:0] in_h [MAXE];
    logic            rst_h [MAXE];
    logic [N_CH-1:0] m_out = RV, m_rise = '0, m_fall = '0, m_long = '0;
    logic            m_any = 1'b0;
    int              rise_edge [N_CH];
    int              ec = 0;

    function automatic logic [N_CH-1:0] s_at(input int t);
        if (t < SYNC) return RV;
        for (int d = 1; d <= SYNC; d++)
            if (rst_h[t-d]) return RV;
        return in_h[t-SYNC];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ec);
        end
    endtask

    task automatic model_step();
        logic [N_CH-1:0] old_out;
        logic            flip;
        if (ec >= MAXE) begin
            $display("FAIL edge_budget: got %0d expected below %0d", ec, MAXE);
            $fatal(1);
        end
        in_h[ec]  = pb_in;
        rst_h[ec] = rst;
        if (rst) begin
            m_out = RV; m_rise = '0; m_fall = '0; m_long = '0; m_any = 1'b0;
            for (int c = 0; c < N_CH; c++) rise_edge[c] = -1;
        end else begin
            old_out = m_out;
            for (int c = 0; c < N_CH; c++) begin
                flip = (ec >= WIN + SYNC);
                for (int j = 0; j < WIN && flip; j++) begin
                    if (j > 0 && rst_h[ec-j]) flip = 1'b0;
                    if (s_at(ec-j)[c] == old_out[c]) flip = 1'b0;
                end
                m_long[c] = old_out[c] && rise_edge[c] >= 0 && (ec - rise_edge[c] == LONG_T);
                if (flip) begin
                    m_out[c] = ~old_out[c];
                    if (m_out[c]) rise_edge[c] = ec;
                end
            end
            m_rise = m_out & ~old_out;
            m_fall = old_out & ~m_out;
            m_any  = |(m_rise | m_fall);
        end
        ec++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("pb_out", pb_out, m_out);
        chk("pb_rise", pb_rise, m_rise);
        chk("pb_fall", pb_fall, m_fall);
        chk("pb_long", pb_long, m_long);
        chk("any_change", any_change, m_any);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int nlong;
        int long_at;
        int hold [N_CH];

        // Reset state
        idle(3);
        chk("rst_out", pb_out, 0);
        chk("rst_any", any_change, 0);
        rst = 1'b0;

        // Clean press on ch0
        pb_in = 4'b0001;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 17) chk("t1_out_early", pb_out[0], 0);
            if (i == 18) begin
                chk("t1_out", pb_out[0], 1);
                chk("t1_rise", pb_rise[0], 1);
                chk("t1_any", any_change, 1);
            end
            if (i == 19) begin
                chk("t1_rise_clr", pb_rise[0], 0);
                chk("t1_any_clr", any_change, 0);
            end
        end
        pb_in = '0;
        idle(20);

        // Bounce on ch1
        pb_in[1] = 1'b1; idle(10);
        pb_in[1] = 1'b0; idle(1);
        pb_in[1] = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 17) chk("t2_out_early", pb_out[1], 0);
            if (i == 18) chk("t2_rise", pb_rise[1], 1);
        end
        pb_in = '0;
        idle(20);

        // 15-cycle glitch on every channel
        pb_in = 4'b1111;
        idle(15);
        pb_in = '0;
        for (int i = 0; i < 25; i++) begin
            tick();
            chk("t3_out", pb_out, 0);
        end

        // Long press on ch2
        pb_in = 4'b0100;
        idle(17);
        tick();
        chk("t4_rise", pb_rise[2], 1);
        nlong = 0; long_at = -1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (pb_long[2]) begin nlong++; long_at = i; end
        end
        chk("t4_long_count", nlong, 1);
        chk("t4_long_pos", long_at, LONG_T);
        pb_in = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 18) chk("t4_fall", pb_fall[2], 1);
        end
        pb_in = 4'b0100;
        nlong = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (pb_long[2]) nlong++; end
        pb_in = '0;
        for (int i = 0; i < 20; i++) begin tick(); if (pb_long[2]) nlong++; end
        chk("t4_short_nolong", nlong, 0);

        // Simultaneous press on ch0 and ch3
        pb_in = 4'b1001;
        idle(17);
        tick();
        chk("t5_rise", pb_rise, 4'b1001);
        chk("t5_any", any_change, 1);
        tick();
        chk("t5_any_clr", any_change, 0);
        pb_in = '0;
        idle(20);

        // Reset mid-window, then mid-press
        pb_in = 4'b0010;
        idle(8);
        rst = 1'b1; tick();
        chk("t6_out_a", pb_out, 0);
        chk("t6_pulses_a", {pb_rise, pb_fall, pb_long}, 0);
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 18) chk("t6_rise_a", pb_rise[1], 1);
        end
        idle(10);
        rst = 1'b1; tick();
        chk("t6_out_b", pb_out, 0);
        chk("t6_fall_b", pb_fall, 0);
        rst = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (i == 18) chk("t6_rise_b", pb_rise[1], 1);
        end
        pb_in = '0;
        idle(20);

        // Random pin activity with occasional resets
        for (int c = 0; c < N_CH; c++) hold[c] = $urandom_range(1, 30);
        for (int n = 0; n < 2000; n++) begin
            for (int c = 0; c < N_CH; c++) begin
                if (hold[c] == 0) begin
                    pb_in[c] = ~pb_in[c];
                    case ($urandom_range(0, 2))
                        0:       hold[c] = $urandom_range(0, 5);
                        1:       hold[c] = $urandom_range(10, 20);
                        default: hold[c] = $urandom_range(20, 100);
                    endcase
                end else begin
                    hold[c]--;
                end
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish by 2000000");
        $fatal(1);
    end

endmodule

// File: doc/button_debouncer_multi.md
Name: button_debouncer_multi

Overview:
Parametrised multi-channel push-button debouncer for the mic array control panel and the slide switches. Each channel synchronises its raw input and filters it with a saturating-window counter. The debounced level only changes after the new input level has held for 2^CNT_W consecutive clocks. Each channel also produces single-cycle press and release pulses, and a per-channel long-press pulse, so that downstream FSMs do not need their own edge detectors.

Parameters:
N_CH, 4, number of independent button channels
CNT_W, 20, debounce counter width; the window is 2^CNT_W clocks (about 21 ms at 50 MHz; benches use 4)
SYNC_STAGES, 2, flip-flop depth of the input synchroniser, minimum 2
LONG_W, 26, long-press counter width; the threshold is 2^LONG_W clocks (about 1.34 s at 50 MHz; benches use 6)
RESET_VAL, {N_CH{1'b0}}, debounced level loaded into pb_out at reset, per channel

Ports:
clk  input  1  system clock, 50 MHz
rst  input  1  synchronous, active-high reset
pb_in  input  N_CH  raw, asynchronous button levels
pb_out  output  N_CH  debounced levels
pb_rise  output  N_CH  one-cycle pulse when pb_out goes 0->1
pb_fall  output  N_CH  one-cycle pulse when pb_out goes 1->0
pb_long  output  N_CH  one-cycle pulse when pb_out has been 1 for 2^LONG_W clocks
any_change  output  1  OR of pb_rise and pb_fall across all channels, registered with them

Behaviour:
- Reset is sampled on the clk rising edge only. While rst=1:
  - synchroniser stages load RESET_VAL;
  - pb_out=RESET_VAL;
  - all debounce and long counters are 0;
  - pb_rise, pb_fall, pb_long and any_change are 0.
  - Reset has priority over everything.
- Channels are fully independent; channel i uses pb_in[i] only.
- Synchroniser: SYNC_STAGES-deep shift chain per channel; the last stage is s[i].
- Debounce, evaluated per clock, per channel:
  - s[i]==pb_out[i]: cnt[i] is set to 0.
  - Otherwise cnt[i] increments (CNT_W bits, wraps to 0).
  - If s[i]!=pb_out[i] and cnt[i]==all-ones, then pb_out[i] is set to s[i] on that same edge.
- Latency:
  - pb_in[i] changes before edge k and then stays stable.
  - pb_out[i] changes on edge k + SYNC_STAGES + 2^CNT_W - 1.
  - With SYNC_STAGES=2 and CNT_W=4 this is edge k+17.
- Bounce: any cycle where s[i] equals pb_out[i] returns cnt[i] to 0 and restarts the window. There is no partial credit.
- Edge pulses:
  - pb_rise[i] is registered and is 1 for exactly the one cycle following the edge where pb_out[i] goes 0->1. It is coincident with the first cycle pb_out[i] reads 1.
  - pb_fall[i] behaves the same for 1->0.
  - pb_rise and pb_fall are never both 1 on one channel.
- any_change is registered from the same next-state terms, so it is coincident with the pulses.
- Long press:
  - lcnt[i] is cleared whenever pb_out[i]==0.
  - While pb_out[i]==1, lcnt[i] increments and saturates at all-ones; it does not wrap.
  - pb_long[i] is 1 for exactly the one cycle in which lcnt[i] first becomes all-ones, at most once per press.
  - lcnt[i] counts from the first cycle pb_out[i]==1. pb_long[i] asserts 2^LONG_W - 1 cycles after pb_rise[i].
- Release before threshold: lcnt clears and there is no pb_long. A new press starts a fresh count.
- Simultaneous events across channels are all reported in the same cycle. any_change covers them all with a single 1.
- Reset mid-window or mid-press:
  - counters abort;
  - pb_out returns to RESET_VAL;
  - no pulse is generated by the reset itself.
  - After rst deasserts, a held button whose level differs from RESET_VAL is debounced from cnt=0 and produces a normal pb_rise.
- No combinational path from pb_in to any output. All outputs come directly from flops.

Test Plan:
1. Clean press, CNT_W=4, ch0: pb_in[0] goes 0->1 before edge 10 and is held -> pb_out[0]=1 and pb_rise[0]=1 after edge 27 only. pb_rise[0]=0 after edge 28. any_change=1 for that one cycle.
2. Bounce, ch1: pb_in[1] high for 10 cycles, low 1 cycle, high and held -> no change until a full 16-cycle stable window. pb_out[1] rises 17 cycles after the final 0->1, with one pb_rise.
3. Short glitch, all channels: 15-cycle high pulses -> pb_out stays 0. No pulses.
4. Long press, LONG_W=6, ch2: held high for 100 cycles after pb_out rises -> pb_long[2] is 1 exactly once, 63 cycles after pb_rise[2]. Release gives pb_fall[2] 17 cycles after the pin falls. Then a 30-cycle press gives no pb_long.
5. Simultaneous: ch0 and ch3 pressed on the same cycle -> both pb_rise bits in the same cycle. any_change is 1 for one cycle only.
6. Reset: rst=1 for 1 cycle during cycle 8 of a window and again during a held press -> all outputs 0 on the next cycle. The held button re-debounces and produces a fresh pb_rise 17 cycles after rst drops.
